flash_arbiter: RTL and testbench

//  Shares the single DSPI flash byte reader between NUM_PORTS requesters (e.g. ROM loader, cart/tape image loader, OSD).

---
 rtl/flash_arb_pkg.sv | 20 ++
 rtl/flash_rr_arbiter.sv | 32 +++
 rtl/flash_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_flash_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the DSPI flash arbiter.
package flash_arb_pkg;

  localparam int unsigned FLASH_AW = 24;
  localparam int unsigned FLASH_DW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StRetry,
    StWaitDone
  } arb_state_e;

  // Round-robin successor: ptr+1, wrapping n-1 back to 0.
  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/flash_rr_arbiter.sv
// Combinational round-robin pick: first requesting port at or after ptr.
module flash_rr_arbiter #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned IdxW      = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IdxW-1:0]      ptr,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IdxW-1:0]      grant_idx,
  output logic                 any
);

  int unsigned j;

  // Scan upward from ptr with wrap; the first requester found wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      j = 32'(ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!any && req[j[IdxW-1:0]]) begin
        any                  = 1'b1;
        grant[j[IdxW-1:0]]   = 1'b1;
        grant_idx            = j[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/flash_arbiter.sv
// Shares one DSPI flash byte reader between NUM_PORTS level-req / pulse-ack requesters.
// Optional per-port last-read cache is enabled by defining FLASH_ARB_CACHE_EN.
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS    = 3,
  parameter int unsigned BUSY_TIMEOUT = 15,
  parameter int unsigned CS_LOW_MIN   = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS*FLASH_AW-1:0] addr,
  output logic [NUM_PORTS-1:0]          ack,
  output logic [FLASH_DW-1:0]           rdata,
  input  logic                          flash_ready,
  input  logic                          flash_busy,
  input  logic [FLASH_DW-1:0]           flash_dout,
  output logic [FLASH_AW-1:0]           flash_addr,
  output logic                          flash_cs
);

  localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CntW = $clog2(CS_LOW_MIN + 1);
  localparam int unsigned TmoW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e           state_q, state_d;
  logic [IdxW-1:0]      rr_q, rr_d, gidx_q, gidx_d;
  logic [CntW-1:0]      cslow_q, cslow_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic [FLASH_AW-1:0]  faddr_q, faddr_d;
  logic [FLASH_DW-1:0]  rdata_q, rdata_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;

  logic [FLASH_AW-1:0]  port_addr [NUM_PORTS];
  logic [FLASH_AW-1:0]  rr_addr;
  logic [NUM_PORTS-1:0] req_eff, rr_grant;
  logic [IdxW-1:0]      rr_idx;
  logic                 rr_any;
  logic                 done;
  logic                 hit_any;
  logic [NUM_PORTS-1:0] hit_oh;
  logic [FLASH_DW-1:0]  hit_data;

  // A port is not re-served in its own ack cycle; req is still high there.
  assign req_eff = req & ~ack_q;
  assign done    = (state_q == StWaitDone) && !flash_busy;

  flash_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IdxW      (IdxW)
  ) u_rr (
    .req       (req_eff),
    .ptr       (rr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any       (rr_any)
  );

  // Split the packed address bus and mux the granted port's address.
  always_comb begin
    rr_addr = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      port_addr[i] = addr[i*FLASH_AW +: FLASH_AW];
      if (rr_grant[i]) rr_addr = rr_addr | port_addr[i];
    end
  end

`ifdef FLASH_ARB_CACHE_EN
  logic                c_valid_q [NUM_PORTS];
  logic [FLASH_AW-1:0] c_addr_q  [NUM_PORTS];
  logic [FLASH_DW-1:0] c_data_q  [NUM_PORTS];
  logic                hit_found;

  // Lowest-index requesting port whose address matches its valid entry.
  always_comb begin
    hit_oh    = '0;
    hit_data  = '0;
    hit_found = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!hit_found && req_eff[i] && c_valid_q[i] && (c_addr_q[i] == port_addr[i])) begin
        hit_found = 1'b1;
        hit_oh[i] = 1'b1;
        hit_data  = c_data_q[i];
      end
    end
  end
  assign hit_any = hit_found;

  // Record each completed flash read against the port that asked for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) c_valid_q[i] <= 1'b0;
    end else if (done) begin
      c_valid_q[gidx_q] <= 1'b1;
      c_addr_q[gidx_q]  <= faddr_q;
      c_data_q[gidx_q]  <= flash_dout;
    end
  end
`else
  assign hit_any  = 1'b0;
  assign hit_oh   = '0;
  assign hit_data = '0;
`endif

  // Next-state logic for grant, cs handshake, timeout retry and completion.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    cslow_d = (cslow_q != '0) ? cslow_q - 1'b1 : cslow_q;
    tmo_d   = tmo_q;
    faddr_d = faddr_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (hit_any) begin
          ack_d   = hit_oh;
          rdata_d = hit_data;
        end else if (flash_ready && (cslow_q == '0) && rr_any) begin
          gidx_d  = rr_idx;
          faddr_d = rr_addr;
          state_d = StIssue;
        end
      end
      StIssue: begin
        tmo_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (flash_busy) begin
          state_d = StWaitDone;
        end else if (tmo_q == TmoW'(BUSY_TIMEOUT - 1)) begin
          cslow_d = CntW'(CS_LOW_MIN);
          state_d = StRetry;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StRetry: begin
        if (cslow_q == '0) state_d = StIssue;
      end
      StWaitDone: begin
        if (!flash_busy) begin
          rdata_d        = flash_dout;
          ack_d[gidx_q]  = 1'b1;
          rr_d           = IdxW'(next_rr(32'(gidx_q), NUM_PORTS));
          cslow_d        = CntW'(CS_LOW_MIN);
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rr_q    <= '0;
      gidx_q  <= '0;
      cslow_q <= CntW'(CS_LOW_MIN);
      tmo_q   <= '0;
      faddr_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      cslow_q <= cslow_d;
      tmo_q   <= tmo_d;
      faddr_q <= faddr_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign flash_addr = faddr_q;
  assign flash_cs   = (state_q == StIssue) || (state_q == StWaitBusy);

endmodule

// File: tb/tb_flash_arbiter.sv
// Scoreboard bench for flash_arbiter with a behavioural DSPI reader model.
// Covers the FLASH_ARB_CACHE_EN hit path when that macro is defined.
module tb_flash_arbiter;

  localparam int unsigned NP      = 3;
  localparam int unsigned BUSY_TO = 15;
  localparam int unsigned CS_MIN  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NP-1:0] req = '0;
  logic [NP*24-1:0] addr = '0;
  logic [NP-1:0] ack;
  logic [7:0]    rdata;
  logic          flash_ready = 1'b1;
  logic          flash_busy;
  logic [7:0]    flash_dout;
  logic [23:0]   flash_addr;
  logic          flash_cs;

  flash_arbiter #(
    .NUM_PORTS    (NP),
    .BUSY_TIMEOUT (BUSY_TO),
    .CS_LOW_MIN   (CS_MIN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .addr        (addr),
    .ack         (ack),
    .rdata       (rdata),
    .flash_ready (flash_ready),
    .flash_busy  (flash_busy),
    .flash_dout  (flash_dout),
    .flash_addr  (flash_addr),
    .flash_cs    (flash_cs)
  );

  always #5 clk = ~clk;

  // Reader model: busy rises 2 cycles after a cs rising edge, stays high 23 cycles.
  int          edge_cnt = 0;
  int          ignore_edge_no = -1;
  logic        m_cs_prev;
  int          m_dly, m_bcnt;
  logic [23:0] m_addr;
  always @(posedge clk) begin
    if (reset) begin
      flash_busy <= 1'b0;
      flash_dout <= 8'h00;
      m_cs_prev  <= 1'b0;
      m_dly      <= 0;
      m_bcnt     <= 0;
    end else begin
      m_cs_prev <= flash_cs;
      if (flash_cs && !m_cs_prev) begin
        edge_cnt <= edge_cnt + 1;
        if (edge_cnt != ignore_edge_no) begin
          m_dly  <= 2;
          m_addr <= flash_addr;
        end
      end
      if (m_dly > 0) begin
        m_dly <= m_dly - 1;
        if (m_dly == 1) begin
          flash_busy <= 1'b1;
          m_bcnt     <= 23;
          flash_dout <= m_addr[7:0] ^ 8'h5A;
        end
      end
      if (flash_busy) begin
        if (m_bcnt == 0) flash_busy <= 1'b0;
        else m_bcnt <= m_bcnt - 1;
      end
    end
  end

  // Scoreboard state.
  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  exp_data [NP][$];
  int          exp_order [$];
  logic [23:0] addr_log [$];
  int          cs_rises = 0, total_acks = 0, cs_run_limit = 4;
  int          ack_mark [NP];
  logic [NP-1:0] pend = '0, drop_pending = '0;
  bit          rand_en = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_cond(input string name, input bit ok, input int act, input int lim);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, bound %0d", name, act, lim);
    end
  endtask

  // Monitor: cs timing rules and ack/rdata against the expected queues.
  int   hi_run = 0, lo_run = 100;
  logic mon_cs_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (flash_cs) begin
        if (!mon_cs_prev) begin
          cs_rises++;
          check_cond("cs_low_gap", lo_run >= int'(CS_MIN), lo_run, int'(CS_MIN));
          addr_log.push_back(flash_addr);
          hi_run = 0;
        end
        hi_run++;
      end else begin
        if (mon_cs_prev) begin
          check_cond("cs_high_len", hi_run <= cs_run_limit, hi_run, cs_run_limit);
          lo_run = 0;
        end
        lo_run++;
      end
      mon_cs_prev = flash_cs;
      if (ack != '0) begin
        check_cond("ack_onehot", $countones(ack) == 1, int'(ack), 1);
        for (int p = 0; p < int'(NP); p++) begin
          if (ack[p]) begin
            check_cond("ack_expected", exp_data[p].size() > 0, exp_data[p].size(), 1);
            if (exp_data[p].size() > 0) check_eq("rdata", rdata, exp_data[p].pop_front());
            if (exp_order.size() > 0) check_eq("ack_order", p, exp_order.pop_front());
`ifndef FLASH_ARB_CACHE_EN
            check_cond("starvation", total_acks - ack_mark[p] <= int'(NP) - 1,
                       total_acks - ack_mark[p], int'(NP) - 1);
`endif
            total_acks++;
          end
        end
      end
    end
  end

  // Requester side: raise a request and queue its expected byte.
  task automatic raise(input int p, input logic [23:0] a);
    addr[p*24 +: 24] = a;
    req[p]           = 1'b1;
    pend[p]          = 1'b1;
    ack_mark[p]      = total_acks;
    exp_data[p].push_back(a[7:0] ^ 8'h5A);
  endtask

  // One cycle of requester behaviour: drop req the cycle after ack; optionally raise new ones.
  task automatic tick();
    @(negedge clk);
    for (int p = 0; p < int'(NP); p++) begin
      if (drop_pending[p]) begin
        req[p]          = 1'b0;
        drop_pending[p] = 1'b0;
        pend[p]         = 1'b0;
      end else if (req[p] && ack[p]) begin
        drop_pending[p] = 1'b1;
      end else if (rand_en && !pend[p] && $urandom_range(7) == 0) begin
        raise(p, 24'($urandom));
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((pend != '0 || drop_pending != '0) && n < budget) begin
      tick();
      n++;
    end
    check_cond("idle_timeout", pend == '0, n, budget);
  endtask

  initial begin
    int n, r0, a0, cnt, log_start;
    logic [23:0] t2a [3];
    for (int p = 0; p < int'(NP); p++) ack_mark[p] = 0;

    // Reset values.
    repeat (3) tick();
    check_eq("rst_ack", ack, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_cs", flash_cs, 0);
    check_eq("rst_faddr", flash_addr, 0);
    reset = 1'b0;

    // All three ports together from rr=0: served 0,1,2, each address issued once.
    tick();
    t2a[0] = 24'h00A101; t2a[1] = 24'h00B202; t2a[2] = 24'h00C303;
    log_start = addr_log.size();
    for (int p = 0; p < 3; p++) begin
      exp_order.push_back(p);
      raise(p, t2a[p]);
    end
    wait_idle(400);
    for (int k = 0; k < 3; k++) begin
      cnt = 0;
      for (int i = log_start; i < addr_log.size(); i++) if (addr_log[i] == t2a[k]) cnt++;
      check_eq("addr_once", cnt, 1);
    end

    // Single port 0: rdata 6E, ack within 40 cycles.
    repeat (4) tick();
    raise(0, 24'h001234);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack[0] && n < 80);
    check_cond("t1_ack_latency", ack[0] && n <= 40, n, 40);
    wait_idle(100);

    // Port 1 back-to-back while port 2 waits: order 1,2,1.
    repeat (4) tick();
    exp_order.push_back(1); exp_order.push_back(2); exp_order.push_back(1);
    raise(1, 24'h0111AB);
    repeat (5) tick();
    raise(2, 24'h0222CD);
    n = 0;
    while (pend[1] && n < 200) begin
      tick();
      n++;
    end
    check_cond("t3_port1_done", !pend[1], n, 200);
    tick();
    raise(1, 24'h0333EF);
    wait_idle(300);
    check_eq("t3_order_drained", exp_order.size(), 0);

    // Reader ignores the first cs edge: timeout, cs low gap, reissue, single ack.
    repeat (4) tick();
    ignore_edge_no = edge_cnt;
    cs_run_limit   = int'(BUSY_TO) + 1;
    r0 = cs_rises; a0 = total_acks;
    raise(2, 24'h045678);
    wait_idle(300);
    check_eq("t4_cs_rises", cs_rises - r0, 2);
    check_eq("t4_acks", total_acks - a0, 1);
    cs_run_limit = 4;

    // flash_ready low holds off any grant; transfer completes after it rises.
    repeat (4) tick();
    flash_ready = 1'b0;
    raise(1, 24'h0ABC99);
    r0 = cs_rises; a0 = total_acks;
    repeat (100) tick();
    check_eq("t5_no_cs", cs_rises - r0, 0);
    check_eq("t5_no_ack", total_acks - a0, 0);
    flash_ready = 1'b1;
    wait_idle(200);
    check_eq("t5_ack_after_ready", total_acks - a0, 1);

    // Reset during WAIT_DONE: outputs cleared next cycle, no ack afterwards.
    repeat (4) tick();
    raise(0, 24'h00BEEF);
    n = 0;
    while (!(flash_busy && !flash_cs) && n < 100) begin
      tick();
      n++;
    end
    check_cond("t6_reach_done", flash_busy && !flash_cs, n, 100);
    repeat (3) tick();
    reset = 1'b1;
    req[0] = 1'b0; pend[0] = 1'b0; drop_pending[0] = 1'b0;
    exp_data[0].delete();
    a0 = total_acks;
    tick();
    check_eq("t6_ack", ack, 0);
    check_eq("t6_cs", flash_cs, 0);
    check_eq("t6_faddr", flash_addr, 0);
    check_eq("t6_rdata", rdata, 0);
    reset = 1'b0;
    repeat (40) tick();
    check_eq("t6_no_late_ack", total_acks - a0, 0);

`ifdef FLASH_ARB_CACHE_EN
    // Repeated address on port 0 is served from the cache one cycle later, no cs edge.
    raise(0, 24'h000010);
    wait_idle(100);
    repeat (4) tick();
    r0 = cs_rises;
    raise(0, 24'h000010);
    tick();
    check_eq("cache_hit_ack", ack[0], 1);
    wait_idle(20);
    check_eq("cache_no_cs", cs_rises - r0, 0);
`endif

    // Randomized traffic from all ports.
    rand_en = 1'b1;
    repeat (3000) tick();
    rand_en = 1'b0;
    wait_idle(600);
    for (int p = 0; p < int'(NP); p++) check_eq("queue_drained", exp_data[p].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
